// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM states, scan-result kinds
// and the physical key layout.
package keypad_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_PRESSED  = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    typedef enum logic [1:0] {
        SCAN_NONE   = 2'd0,
        SCAN_SINGLE = 2'd1,
        SCAN_MULTI  = 2'd2
    } scan_kind_t;

    // Nibble {row,col} holds the hex code printed on that key ('*'=E, '#'=F).
    localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

    function automatic logic [3:0] key_code(input logic [1:0] row_idx, input logic [1:0] col_idx);
        logic [5:0] base;
        base = {row_idx, col_idx, 2'b00};
        return KEY_MAP[base +: 4];
    endfunction

endpackage

// File: rtl/keypad_col_scan.sv
// Column rotation, row synchronisation and per-scan accumulation. Emits one
// scan_done pulse per full 4-column sweep with the classified result.
module keypad_col_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       scan_done,
    output logic [1:0] scan_kind,
    output logic [3:0] scan_code
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [3:0]       row_meta_q, row_sync_q;
    logic [DIV_W-1:0] div_q;
    logic [1:0]       col_idx_q;
    logic [3:0]       col_q;
    logic [1:0]       acc_cnt_q, acc_cnt_d;
    logic [3:0]       acc_code_q, acc_code_d;
    logic             scan_done_q;
    logic [1:0]       scan_kind_q, kind_d;
    logic [3:0]       scan_code_q;
    logic             slot_end;
    logic [2:0]       hit_cnt;
    logic [3:0]       hit_code;
    logic [2:0]       total;

    assign slot_end = (div_q == DIV_LAST);

    // Merge this column's hits into the running scan; count saturates at 2 (= MULTI).
    always_comb begin
        hit_cnt  = 3'd0;
        hit_code = 4'h0;
        for (int r = 0; r < 4; r++) begin
            if (!row_sync_q[r]) begin
                hit_cnt  = hit_cnt + 3'd1;
                hit_code = key_code(2'(r), col_idx_q);
            end
        end
        total      = {1'b0, acc_cnt_q} + hit_cnt;
        acc_cnt_d  = (total >= 3'd2) ? 2'd2 : total[1:0];
        acc_code_d = (hit_cnt != 3'd0) ? hit_code : acc_code_q;
        kind_d     = SCAN_NONE;
        if (total == 3'd1)
            kind_d = SCAN_SINGLE;
        else if (total >= 3'd2)
            kind_d = SCAN_MULTI;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta_q  <= 4'b1111;
            row_sync_q  <= 4'b1111;
            div_q       <= '0;
            col_idx_q   <= 2'd0;
            col_q       <= 4'b1110;
            acc_cnt_q   <= 2'd0;
            acc_code_q  <= 4'h0;
            scan_done_q <= 1'b0;
            scan_kind_q <= SCAN_NONE;
            scan_code_q <= 4'h0;
        end else begin
            row_meta_q  <= row;
            row_sync_q  <= row_meta_q;
            scan_done_q <= 1'b0;
            if (slot_end) begin
                div_q     <= '0;
                col_idx_q <= col_idx_q + 2'd1;
                col_q     <= {col_q[2:0], col_q[3]};
                if (col_idx_q == 2'd3) begin
                    scan_done_q <= 1'b1;
                    scan_kind_q <= kind_d;
                    scan_code_q <= acc_code_d;
                    acc_cnt_q   <= 2'd0;
                    acc_code_q  <= 4'h0;
                end else begin
                    acc_cnt_q  <= acc_cnt_d;
                    acc_code_q <= acc_code_d;
                end
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
        end
    end

    assign col       = col_q;
    assign scan_done = scan_done_q;
    assign scan_kind = scan_kind_q;
    assign scan_code = scan_code_q;

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x4 keypad scanner top: debounces full-scan results and publishes one hex
// code per physical press, with a single-cycle valid strobe.
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_val,
    output logic       key_valid,
    output logic       key_held
);

    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

    logic             scan_done;
    logic [1:0]       scan_kind;
    logic [3:0]       scan_code;
    logic [1:0]       state_q, state_d;
    logic [3:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]       key_val_q, key_val_d;
    logic             key_valid_q, key_valid_d;
    logic             key_held_q, key_held_d;
    logic             is_none, is_single;

    keypad_col_scan #(.SCAN_DIV(SCAN_DIV)) u_col_scan (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .col       (col),
        .scan_done (scan_done),
        .scan_kind (scan_kind),
        .scan_code (scan_code)
    );

    assign is_none   = (scan_kind == SCAN_NONE);
    assign is_single = (scan_kind == SCAN_SINGLE);
    assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        key_val_d   = key_val_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        if (scan_done) begin
            case (state_q)
                ST_IDLE: begin
                    if (is_single) begin
                        cand_d  = scan_code;
                        cnt_d   = CNT_W'(1);
                        state_d = ST_DEBOUNCE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (is_single && scan_code == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            state_d     = ST_PRESSED;
                            key_val_d   = cand_q;
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                        end
                    end else if (is_single) begin
                        cand_d = scan_code;
                        cnt_d  = CNT_W'(1);
                    end else if (is_none) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                ST_PRESSED: begin
                    if (is_none) begin
                        cnt_d   = CNT_W'(1);
                        state_d = ST_RELEASE;
                    end
                end
                default: begin
                    // Any key seen during release means the press never ended.
                    if (is_none) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            state_d    = ST_IDLE;
                            key_held_d = 1'b0;
                            cnt_d      = '0;
                        end
                    end else begin
                        state_d = ST_PRESSED;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cand_q      <= 4'h0;
            cnt_q       <= '0;
            key_val_q   <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            key_val_q   <= key_val_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign key_val   = key_val_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Self-checking bench: models the membrane matrix and predicts key events
// from press/release periods using the keypad's debounce rules.
module tb_keypad_matrix_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DS       = 3;
    localparam int SCAN     = 4 * SCAN_DIV;
    localparam int LAT_MAX  = (DS + 1) * 4 * SCAN_DIV + 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row, col, key_val;
    logic        key_valid, key_held;
    logic [15:0] keys = 16'h0;

    int         checks_total  = 0;
    int         checks_passed = 0;
    int         cyc           = 0;
    int         pulse_cnt     = 0;
    int         first_cyc     = 0;
    logic [3:0] first_val     = 4'h0;
    int         stray_changes = 0;
    logic [3:0] prev_val      = 4'h0;

    always #5 clk = ~clk;

    keypad_matrix_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DS)) dut (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .col       (col),
        .key_val   (key_val),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    // Physical matrix: a row reads low when any pressed key on it sits in the driven column.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && col[c] == 1'b0)
                    row[r] = 1'b0;
    end

    always @(posedge clk) begin
        #1;
        cyc++;
        if (key_valid) begin
            if (pulse_cnt == 0) begin
                first_cyc = cyc;
                first_val = key_val;
            end
            pulse_cnt++;
        end
        if (!rst && key_val !== prev_val && key_valid !== 1'b1)
            stray_changes++;
        prev_val = key_val;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] hex_of(input int r, input int c);
        string layout;
        int    ch;
        layout = "123A456B789C*0#D";
        ch = int'(layout[r*4+c]);
        if (ch >= 48 && ch <= 57) return 4'(ch - 48);
        if (ch >= 65 && ch <= 70) return 4'(ch - 55);
        if (ch == 42) return 4'hE;
        return 4'hF;
    endfunction

    function automatic logic [15:0] key_bit(input int r, input int c);
        logic [15:0] v;
        v = 16'h0;
        v[r*4+c] = 1'b1;
        return v;
    endfunction

    task automatic hold_keys(input logic [15:0] k, input int n, input bit track_all,
                             output int start, output int held_low);
        keys = k;
        pulse_cnt = 0;
        start = cyc;
        held_low = 0;
        repeat (n) begin
            @(negedge clk);
            if ((track_all || pulse_cnt > 0) && key_held !== 1'b1) held_low++;
        end
    endtask

    task automatic wait_release(output int fall);
        int start;
        keys = 16'h0;
        pulse_cnt = 0;
        start = cyc;
        fall = -1;
        for (int i = 0; i < 100 && fall < 0; i++) begin
            @(negedge clk);
            if (key_held === 1'b0) fall = cyc - start;
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_col;
        rst = 1'b1;
        keys = 16'h0;
        repeat (3) @(negedge clk);
        checks_total++; if (col !== 4'b1110) $display("FAIL reset_col: got %b expected 1110", col); else checks_passed++;
        checks_total++; if (key_val !== 4'h0) $display("FAIL reset_key_val: got %h expected 0", key_val); else checks_passed++;
        checks_total++; if (key_valid !== 1'b0) $display("FAIL reset_key_valid: got %b expected 0", key_valid); else checks_passed++;
        checks_total++; if (key_held !== 1'b0) $display("FAIL reset_key_held: got %b expected 0", key_held); else checks_passed++;
        rst = 1'b0;
        pulse_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            exp_col = 4'hF;
            exp_col[(i / SCAN_DIV) % 4] = 1'b0;
            checks_total++;
            if (col !== exp_col) $display("FAIL idle_col_%0d: got %b expected %b", i, col, exp_col);
            else checks_passed++;
            @(negedge clk);
        end
        repeat (48) @(negedge clk);
        checks_total++; if (pulse_cnt !== 0) $display("FAIL idle_pulses: got %0d expected 0", pulse_cnt); else checks_passed++;
        checks_total++; if (key_val !== 4'h0) $display("FAIL idle_key_val: got %h expected 0", key_val); else checks_passed++;
    endtask

    task automatic test_single_press();
        int start, held_low, fall;
        repeat ($urandom_range(0, 15)) @(negedge clk);
        hold_keys(key_bit(1, 1), 500, 1'b0, start, held_low);
        checks_total++; if (pulse_cnt !== 1) $display("FAIL press5_pulses: got %0d expected 1", pulse_cnt); else checks_passed++;
        checks_total++; if (first_val !== hex_of(1, 1)) $display("FAIL press5_val: got %h expected %h", first_val, hex_of(1, 1)); else checks_passed++;
        checks_total++;
        if (!(pulse_cnt > 0 && first_cyc - start <= LAT_MAX))
            $display("FAIL press5_latency: got %0d cycles expected <= %0d", first_cyc - start, LAT_MAX);
        else checks_passed++;
        checks_total++; if (held_low !== 0) $display("FAIL press5_held: got %0d low cycles expected 0", held_low); else checks_passed++;
        wait_release(fall);
        checks_total++;
        if (fall < 2 * SCAN || fall > LAT_MAX)
            $display("FAIL release5_fall: got %0d cycles expected %0d..%0d", fall, 2 * SCAN, LAT_MAX);
        else checks_passed++;
        checks_total++; if (pulse_cnt !== 0) $display("FAIL release5_pulses: got %0d expected 0", pulse_cnt); else checks_passed++;
    endtask

    task automatic test_bounce();
        int start, held_low, fall;
        pulse_cnt = 0;
        for (int t = 0; t < 8; t++) begin
            keys = (t % 2 == 0) ? key_bit(3, 0) : 16'h0;
            repeat (5) @(negedge clk);
        end
        checks_total++; if (pulse_cnt !== 0) $display("FAIL bounce_pulses: got %0d expected 0", pulse_cnt); else checks_passed++;
        hold_keys(key_bit(3, 0), 100, 1'b0, start, held_low);
        checks_total++; if (pulse_cnt !== 1) $display("FAIL bounce_hold_pulses: got %0d expected 1", pulse_cnt); else checks_passed++;
        checks_total++; if (first_val !== 4'hE) $display("FAIL bounce_hold_val: got %h expected e", first_val); else checks_passed++;
        wait_release(fall);
        checks_total++; if (fall < 0) $display("FAIL bounce_release: got %0d expected held to fall", fall); else checks_passed++;
    endtask

    task automatic test_glitch();
        int start, held_low, fall;
        hold_keys(key_bit(3, 2), 100, 1'b0, start, held_low);
        checks_total++; if (pulse_cnt !== 1) $display("FAIL hash_pulses: got %0d expected 1", pulse_cnt); else checks_passed++;
        checks_total++; if (first_val !== 4'hF) $display("FAIL hash_val: got %h expected f", first_val); else checks_passed++;
        keys = 16'h0;
        pulse_cnt = 0;
        held_low = 0;
        repeat (SCAN) begin
            @(negedge clk);
            if (key_held !== 1'b1) held_low++;
        end
        checks_total++; if (held_low !== 0) $display("FAIL glitch_held: got %0d low cycles expected 0", held_low); else checks_passed++;
        hold_keys(key_bit(3, 2), 100, 1'b1, start, held_low);
        checks_total++; if (pulse_cnt !== 0) $display("FAIL glitch_pulses: got %0d expected 0", pulse_cnt); else checks_passed++;
        checks_total++; if (held_low !== 0) $display("FAIL glitch_rehold: got %0d low cycles expected 0", held_low); else checks_passed++;
        wait_release(fall);
        checks_total++; if (fall < 0) $display("FAIL hash_release: got %0d expected held to fall", fall); else checks_passed++;
    endtask

    task automatic test_two_keys();
        int start, held_low;
        hold_keys(key_bit(0, 0) | key_bit(0, 1), 100, 1'b0, start, held_low);
        checks_total++; if (pulse_cnt !== 0) $display("FAIL multi_pulses: got %0d expected 0", pulse_cnt); else checks_passed++;
        checks_total++; if (key_held !== 1'b0) $display("FAIL multi_held: got %b expected 0", key_held); else checks_passed++;
        hold_keys(key_bit(0, 0), 100, 1'b0, start, held_low);
        checks_total++; if (pulse_cnt !== 1) $display("FAIL multi_drop_pulses: got %0d expected 1", pulse_cnt); else checks_passed++;
        checks_total++; if (first_val !== 4'h1) $display("FAIL multi_drop_val: got %h expected 1", first_val); else checks_passed++;
    endtask

    task automatic test_reset_mid_debounce();
        int start, lat;
        rst = 1'b1;
        keys = key_bit(2, 2);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        pulse_cnt = 0;
        repeat (40) @(negedge clk);
        checks_total++; if (pulse_cnt !== 0) $display("FAIL pre_reset_pulses: got %0d expected 0", pulse_cnt); else checks_passed++;
        #2 rst = 1'b1;
        #1;
        checks_total++; if (col !== 4'b1110) $display("FAIL async_reset_col: got %b expected 1110", col); else checks_passed++;
        checks_total++; if (key_val !== 4'h0) $display("FAIL async_reset_val: got %h expected 0", key_val); else checks_passed++;
        checks_total++; if (key_held !== 1'b0) $display("FAIL async_reset_held: got %b expected 0", key_held); else checks_passed++;
        checks_total++; if (key_valid !== 1'b0) $display("FAIL async_reset_valid: got %b expected 0", key_valid); else checks_passed++;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        pulse_cnt = 0;
        start = cyc;
        repeat (100) @(negedge clk);
        lat = first_cyc - start;
        checks_total++; if (pulse_cnt !== 1) $display("FAIL rearm_pulses: got %0d expected 1", pulse_cnt); else checks_passed++;
        checks_total++; if (first_val !== 4'h9) $display("FAIL rearm_val: got %h expected 9", first_val); else checks_passed++;
        checks_total++;
        if (pulse_cnt == 0 || lat < 3 * SCAN || lat > LAT_MAX)
            $display("FAIL rearm_latency: got %0d cycles expected %0d..%0d", lat, 3 * SCAN, LAT_MAX);
        else checks_passed++;
    endtask

    // Long stable periods of no key, one key or a key pair; '9' is held on entry.
    task automatic test_random();
        bit          m_held;
        logic [3:0]  m_val;
        bit          prev_pair;
        int          sel, k1, k2, len, exp_pulses, start, held_low;
        logic [15:0] set;
        m_held = 1'b1;
        m_val = 4'h9;
        prev_pair = 1'b0;
        for (int p = 0; p < 12; p++) begin
            sel = int'($urandom_range(0, 99));
            k1 = int'($urandom_range(0, 15));
            k2 = (k1 + int'($urandom_range(1, 15))) % 16;
            exp_pulses = 0;
            if (sel < 35) begin
                set = 16'h0;
                m_held = 1'b0;
                prev_pair = 1'b0;
            end else if (sel < 80 || prev_pair) begin
                set = key_bit(k1 / 4, k1 % 4);
                if (!m_held) begin
                    exp_pulses = 1;
                    m_held = 1'b1;
                    m_val = hex_of(k1 / 4, k1 % 4);
                end
                prev_pair = 1'b0;
            end else begin
                set = key_bit(k1 / 4, k1 % 4) | key_bit(k2 / 4, k2 % 4);
                prev_pair = 1'b1;
            end
            len = int'($urandom_range(100, 150));
            hold_keys(set, len, 1'b0, start, held_low);
            checks_total++;
            if (pulse_cnt !== exp_pulses) $display("FAIL rand%0d_pulses: keys %h got %0d expected %0d", p, set, pulse_cnt, exp_pulses);
            else checks_passed++;
            checks_total++;
            if (key_held !== m_held) $display("FAIL rand%0d_held: keys %h got %b expected %b", p, set, key_held, m_held);
            else checks_passed++;
            checks_total++;
            if (key_val !== m_val) $display("FAIL rand%0d_val: keys %h got %h expected %h", p, set, key_val, m_val);
            else checks_passed++;
            if (exp_pulses == 1) begin
                checks_total++;
                if (pulse_cnt == 0 || first_cyc - start > LAT_MAX)
                    $display("FAIL rand%0d_latency: got %0d cycles expected <= %0d", p, first_cyc - start, LAT_MAX);
                else checks_passed++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_glitch();
        test_two_keys();
        test_reset_mid_debounce();
        test_random();
        checks_total++;
        if (stray_changes !== 0) $display("FAIL key_val_without_valid: got %0d changes expected 0", stray_changes);
        else checks_passed++;
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/keypad_matrix_scanner.md
Name: keypad_matrix_scanner

Overview:
- Scans a 4x4 membrane keypad by driving one column low at a time and sampling the four pull-up row lines.
- Debounces the scan result and emits a 4-bit hex key code with a one-cycle valid strobe.
- Sits directly upstream of the hex-to-seven-segment stage, which consumes key_val.
- One code per physical press; the code stays stable until the next accepted press.

Parameters:
- SCAN_DIV, 50000: clk cycles per column slot; minimum 4.
- DEBOUNCE_SCANS, 3: consecutive identical full-scan results needed to accept a press or a release; minimum 2.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- row  in  4  keypad rows; active-low, externally pulled up, asynchronous to clk
- col  out  4  keypad column drive; active-low, exactly one bit low at all times
- key_val  out  4  last accepted key code
- key_valid  out  1  one-cycle pulse when key_val is updated
- key_held  out  1  high while an accepted key is considered down

Behaviour:
- Reset values:
  - col=4'b1110
  - key_val=4'h0, key_valid=0, key_held=0
  - FSM=IDLE; divider, column index and debounce count = 0
  - row synchronizer flops = 4'b1111
- row passes through a 2-FF synchronizer before use.
- Column rotation:
  - Divider counts 0..SCAN_DIV-1.
  - On terminal count the column index advances 0->1->2->3->0.
  - col sequence: 1110, 1101, 1011, 0111.
- Sampling:
  - Synchronized rows are sampled on the divider terminal-count cycle of each slot; the line has settled by then because SCAN_DIV≥4.
  - row[r]==0 during column c means key (r,c) is pressed.
- Key map (row r, col c):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: *=E, 0, #=F, D
- Scan result is formed at the column-3 sample (full-scan boundary). Result is one of:
  - NONE: 0 keys pressed
  - SINGLE(code): exactly 1 key pressed
  - MULTI: 2 or more keys pressed
- FSM advances only at full-scan boundaries:
  - IDLE
    - SINGLE(k): cand=k, cnt=1, go to DEBOUNCE.
    - Otherwise: stay.
  - DEBOUNCE
    - SINGLE(cand): cnt++. When cnt reaches DEBOUNCE_SCANS: go to PRESSED, key_val<=cand, key_valid=1 for exactly one cycle, key_held<=1.
    - SINGLE(other): cand=other, cnt=1.
    - NONE: go to IDLE.
    - MULTI: hold, cnt unchanged.
  - PRESSED
    - NONE: cnt=1, go to RELEASE.
    - Any key (SINGLE or MULTI): stay. A different key while held is ignored until a full release.
  - RELEASE
    - NONE: cnt++. When cnt reaches DEBOUNCE_SCANS: go to IDLE, key_held<=0.
    - SINGLE or MULTI: return to PRESSED. No new key_valid.
- Latency: key_valid asserts no later than (DEBOUNCE_SCANS+1)*4*SCAN_DIV+3 cycles after row lines become stable.
- key_val never changes except together with key_valid.
- Reset mid-operation: all state is discarded. A key still held after reset must be fully re-debounced and then produces a fresh pulse.
- Counters saturate rather than wrap. The debounce count width is ceil(log2(DEBOUNCE_SCANS+1)).

Decomposition:
- keypad_pkg holds:
  - FSM state enum (IDLE, DEBOUNCE, PRESSED, RELEASE)
  - 16-entry key-map constant indexed by {row,col}
  - scan-result kind encoding (NONE/SINGLE/MULTI)
- Sub-module keypad_col_scan owns:
  - row synchronizer, divider and column rotation
  - per-scan accumulation (key count, code)
  - outputs: scan_done pulse, scan_kind, scan_code
- The top level keeps the debounce FSM and the output registers.

Test Plan:
- Bench setup:
  - SCAN_DIV=4, DEBOUNCE_SCANS=3, giving a scan period of 16 cycles.
  - The bench models the matrix: row[r]=0 iff key (r,c) is pressed and col[c]==0.
- Scenario 1 (reset then idle): col=1110 during reset; then cycles 1110,1101,1011,0111, each held 4 cycles; key_valid never asserts; key_val=0.
- Scenario 2 (press '5' (r1,c1) and hold 500 cycles): exactly one key_valid within 67 cycles with key_val=4'h5; key_held=1 throughout; no further pulses.
- Scenario 3 (bounce row3/col0 every 5 cycles for 40 cycles, then hold): no pulse during the bounce; then exactly one pulse with key_val=4'hE.
- Scenario 4 (release '5', then press '#' (r3,c2)):
  - key_held falls 3 scans after release.
  - Second pulse with key_val=4'hF.
  - A 1-scan release glitch inserted between presses produces no extra pulse.
- Scenario 5 (press '1' and '2' together from IDLE): no pulse; releasing '2' gives one pulse with key_val=4'h1.
- Scenario 6 (reset mid-debounce): assert rst after 2 matching scans of '9'; all outputs return to reset values; with '9' still held, exactly one pulse with key_val=4'h9 no sooner than 3 full scans after rst deasserts.
